// File: rtl/dmem_byte_bridge.sv
// dmem_byte_bridge: splits core data-memory accesses into big-endian external byte cycles.
// Optional build macro DMEM_BRIDGE_MISALIGN_EN enables odd-address word accesses.
`default_nettype none

module dmem_byte_bridge #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_mem_assert,
  input  logic              d_mem_cmd,
  input  logic              d_mem_be0,
  input  logic              d_mem_be1,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [15:0]       d_mem_wdata,
  output logic [15:0]       d_mem_rdata,
  output logic              d_mem_rdy,
  output logic              ext_req,
  output logic              ext_we,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [7:0]        ext_wdata,
  input  logic [7:0]        ext_rdata,
  input  logic              ext_rdy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER_HI = 2'd1,
    XFER_LO = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              cmd_q;
  logic              word_q;
  logic [15:0]       wdata_q;
  logic [7:0]        hi_q;
  logic [15:0]       rdata_q;
  logic [ADDR_W-1:0] hi_addr;
  logic [ADDR_W-1:0] lo_addr;
  logic              accept;

  assign accept = (state_q == IDLE) && d_mem_assert;

`ifdef DMEM_BRIDGE_MISALIGN_EN
  assign hi_addr = addr_q;
  assign lo_addr = addr_q + ADDR_W'(1);
`else
  assign hi_addr = {addr_q[ADDR_W-1:1], 1'b0};
  assign lo_addr = {addr_q[ADDR_W-1:1], 1'b1};
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (d_mem_assert) state_d = (d_mem_be0 && d_mem_be1) ? XFER_HI : XFER_LO;
      XFER_HI: if (ext_rdy) state_d = XFER_LO;
      XFER_LO: if (ext_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // External bus is driven purely from the latched request, so it stays stable while stalled.
  always_comb begin
    ext_req   = 1'b0;
    ext_we    = 1'b0;
    ext_addr  = '0;
    ext_wdata = 8'h00;
    case (state_q)
      XFER_HI: begin
        ext_req   = 1'b1;
        ext_we    = cmd_q;
        ext_addr  = hi_addr;
        ext_wdata = wdata_q[15:8];
      end
      XFER_LO: begin
        ext_req   = 1'b1;
        ext_we    = cmd_q;
        ext_addr  = word_q ? lo_addr : addr_q;
        ext_wdata = wdata_q[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cmd_q   <= 1'b0;
      word_q  <= 1'b0;
      wdata_q <= 16'h0000;
      hi_q    <= 8'h00;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= d_mem_addr;
        cmd_q   <= d_mem_cmd;
        word_q  <= d_mem_be0 && d_mem_be1;
        wdata_q <= d_mem_wdata;
      end
      if ((state_q == XFER_HI) && ext_rdy) hi_q <= ext_rdata;
      if ((state_q == XFER_LO) && ext_rdy && !cmd_q)
        rdata_q <= word_q ? {hi_q, ext_rdata} : {8'h00, ext_rdata};
    end
  end

  assign d_mem_rdata = rdata_q;
  assign d_mem_rdy   = (state_q == IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dmem_byte_bridge.sv
// tb_dmem_byte_bridge: directed vector table plus stall, reset and wrap sequences.
`default_nettype none

module tb_dmem_byte_bridge;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              d_mem_assert = 1'b0;
  logic              d_mem_cmd = 1'b0;
  logic              d_mem_be0 = 1'b0;
  logic              d_mem_be1 = 1'b0;
  logic [ADDR_W-1:0] d_mem_addr = '0;
  logic [15:0]       d_mem_wdata = 16'h0000;
  logic [15:0]       d_mem_rdata;
  logic              d_mem_rdy;
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [7:0]        ext_wdata;
  logic [7:0]        ext_rdata;
  logic              ext_rdy = 1'b1;

  logic [7:0]        mem [0:65535];
  logic              pre_en = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [7:0]        pre_data = 8'h00;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_byte_bridge #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .d_mem_assert(d_mem_assert), .d_mem_cmd(d_mem_cmd),
    .d_mem_be0(d_mem_be0), .d_mem_be1(d_mem_be1),
    .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_rdy(d_mem_rdy),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_rdy(ext_rdy)
  );

  assign ext_rdata = mem[ext_addr];

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ext_req && ext_rdy && ext_we) mem[ext_addr] <= ext_wdata;
  end

  typedef struct {
    logic        cmd;
    logic        be0;
    logic        be1;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_cyc;
    logic [15:0] chk_addr;
    logic [7:0]  chk_byte;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preset(input logic [15:0] a, input logic [7:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Issue one request with ext_rdy held at its current value; returns edges from accept to completion.
  task automatic access(input logic cmd, input logic be0, input logic be1,
                        input logic [15:0] addr, input logic [15:0] wdata, output int cyc);
    d_mem_assert = 1'b1; d_mem_cmd = cmd; d_mem_be0 = be0; d_mem_be1 = be1;
    d_mem_addr = addr; d_mem_wdata = wdata;
    @(posedge clk); #1;
    d_mem_assert = 1'b0; d_mem_addr = ~addr; d_mem_wdata = ~wdata; d_mem_cmd = ~cmd;
    chk("rdy_low_after_accept", {31'b0, d_mem_rdy}, 32'd0);
    cyc = 1;
    while (!d_mem_rdy && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    logic [15:0] a0;
    logic [7:0]  d0;

    vecs[0] = '{1'b0, 1'b1, 1'b1, 16'hC002, 16'h0000, 16'hC012, 3, 16'hB004, 8'h77};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 16'hB005, 16'hAB55, 16'hC012, 2, 16'hB005, 8'h55};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 16'hB005, 16'h0000, 16'h0055, 2, 16'hB004, 8'h77};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h1000, 16'hBEEF, 16'h0055, 3, 16'h1000, 8'hBE};
`ifdef DMEM_BRIDGE_MISALIGN_EN
    vecs[4] = '{1'b0, 1'b1, 1'b1, 16'h1001, 16'h0000, 16'hEF5A, 3, 16'h1001, 8'hEF};
`else
    vecs[4] = '{1'b0, 1'b1, 1'b1, 16'h1001, 16'h0000, 16'hBEEF, 3, 16'h1001, 8'hEF};
`endif
    vecs[5] = '{1'b0, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h00BE, 2, 16'h1002, 8'h5A};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 16'hC003, 16'h3499, 16'h00BE, 2, 16'hC003, 8'h99};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 16'hC002, 16'h0000, 16'h00C0, 2, 16'hC002, 8'hC0};

    // Memory presets are loaded while reset is held.
    @(posedge clk); #1;
    preset(16'hC002, 8'hC0); preset(16'hC003, 8'h12); preset(16'hB004, 8'h77);
    preset(16'hB005, 8'h00); preset(16'h1002, 8'h5A); preset(16'h2000, 8'h11);
    preset(16'h2001, 8'h22); preset(16'h0001, 8'h00); preset(16'h0000, 8'hBB);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    chk("reset_rdy",   {31'b0, d_mem_rdy}, 32'd1);
    chk("reset_req",   {31'b0, ext_req}, 32'd0);
    chk("reset_we",    {31'b0, ext_we}, 32'd0);
    chk("reset_addr",  {16'b0, ext_addr}, 32'h0);
    chk("reset_wdata", {24'b0, ext_wdata}, 32'h0);
    chk("reset_rdata", {16'b0, d_mem_rdata}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      access(vecs[i].cmd, vecs[i].be0, vecs[i].be1, vecs[i].addr, vecs[i].wdata, cyc);
      chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cyc);
      chk($sformatf("vec%0d_rdata", i), {16'b0, d_mem_rdata}, {16'b0, vecs[i].exp_rdata});
      chk($sformatf("vec%0d_mem", i), {24'b0, mem[vecs[i].chk_addr]}, {24'b0, vecs[i].chk_byte});
    end

    // Word write at the top of memory with two stall cycles in each byte phase.
    ext_rdy = 1'b0;
    d_mem_assert = 1'b1; d_mem_cmd = 1'b1; d_mem_be0 = 1'b1; d_mem_be1 = 1'b1;
    d_mem_addr = 16'hFFFE; d_mem_wdata = 16'h1234;
    @(posedge clk); #1;
    d_mem_assert = 1'b0; d_mem_wdata = 16'h0000; d_mem_addr = 16'h0000;
    cyc = 1;
    for (int s = 0; s < 3; s++) begin
      chk("stall_hi_req",   {31'b0, ext_req}, 32'd1);
      chk("stall_hi_we",    {31'b0, ext_we}, 32'd1);
      chk("stall_hi_addr",  {16'b0, ext_addr}, 32'hFFFE);
      chk("stall_hi_wdata", {24'b0, ext_wdata}, 32'h12);
      if (s == 2) ext_rdy = 1'b1;
      @(posedge clk); #1; cyc++;
    end
    ext_rdy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("stall_lo_req",   {31'b0, ext_req}, 32'd1);
      chk("stall_lo_addr",  {16'b0, ext_addr}, 32'hFFFF);
      chk("stall_lo_wdata", {24'b0, ext_wdata}, 32'h34);
      chk("stall_lo_rdy",   {31'b0, d_mem_rdy}, 32'd0);
      if (s == 2) ext_rdy = 1'b1;
      @(posedge clk); #1; cyc++;
    end
    chk("stall_cycles", cyc, 7);
    chk("stall_done_rdy", {31'b0, d_mem_rdy}, 32'd1);
    chk("stall_mem_hi", {24'b0, mem[16'hFFFE]}, 32'h12);
    chk("stall_mem_lo", {24'b0, mem[16'hFFFF]}, 32'h34);
    chk("stall_rdata_kept", {16'b0, d_mem_rdata}, 32'h00C0);

    // Reset while the low byte of a word read is outstanding.
    ext_rdy = 1'b0;
    d_mem_assert = 1'b1; d_mem_cmd = 1'b0; d_mem_be0 = 1'b1; d_mem_be1 = 1'b1;
    d_mem_addr = 16'h2000;
    @(posedge clk); #1;
    d_mem_assert = 1'b0;
    ext_rdy = 1'b1;
    @(posedge clk); #1;
    ext_rdy = 1'b0;
    chk("rst_mid_addr", {16'b0, ext_addr}, 32'h2001);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ext_rdy = 1'b1;
    chk("rst_mid_req",   {31'b0, ext_req}, 32'd0);
    chk("rst_mid_rdy",   {31'b0, d_mem_rdy}, 32'd1);
    chk("rst_mid_rdata", {16'b0, d_mem_rdata}, 32'h0);
    access(1'b0, 1'b0, 1'b1, 16'h0001, 16'h0000, cyc);
    chk("post_rst_cycles", cyc, 2);
    chk("post_rst_rdata", {16'b0, d_mem_rdata}, 32'h0);

    // Word read at 0xFFFF: aligned build uses FFFE/FFFF, misaligned build wraps to 0000.
    preset(16'hFFFF, 8'hAA);
    d_mem_assert = 1'b1; d_mem_cmd = 1'b0; d_mem_be0 = 1'b1; d_mem_be1 = 1'b1;
    d_mem_addr = 16'hFFFF;
    @(posedge clk); #1;
    d_mem_assert = 1'b0;
`ifdef DMEM_BRIDGE_MISALIGN_EN
    a0 = 16'hFFFF;
`else
    a0 = 16'hFFFE;
`endif
    chk("wrap_hi_addr", {16'b0, ext_addr}, {16'b0, a0});
    @(posedge clk); #1;
`ifdef DMEM_BRIDGE_MISALIGN_EN
    a0 = 16'h0000;
`else
    a0 = 16'hFFFF;
`endif
    chk("wrap_lo_addr", {16'b0, ext_addr}, {16'b0, a0});
    @(posedge clk); #1;
    chk("wrap_rdy", {31'b0, d_mem_rdy}, 32'd1);
`ifdef DMEM_BRIDGE_MISALIGN_EN
    chk("wrap_rdata", {16'b0, d_mem_rdata}, 32'hAABB);
`else
    chk("wrap_rdata", {16'b0, d_mem_rdata}, 32'h12AA);
`endif

    // Back-to-back: a byte read accepted on the first idle cycle after completion.
    access(1'b0, 1'b1, 1'b0, 16'hC003, 16'h0000, cyc);
    d0 = 8'h99;
    chk("b2b_cycles", cyc, 2);
    chk("b2b_rdata", {16'b0, d_mem_rdata}, {24'b0, d0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
